// File: rtl/trng_pkg.sv
// Shared types and sizing helpers for the ring-oscillator TRNG sampler.
package trng_pkg;

    // Sampler control states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_FAIL   = 2'd3
    } trng_state_e;

    localparam int RO_WIDTH  = 16;
    localparam int BYTE_BITS = 8;
    localparam int BIT_CNT_W = $clog2(BYTE_BITS);

    // Width of a counter that must hold every value 0..max_val (never less than 1 bit)
    function automatic int cnt_width(input int max_val);
        if (max_val < 2) begin
            return 1;
        end else begin
            return $clog2(max_val + 1);
        end
    endfunction

endpackage

// File: rtl/trng_sync2.sv
// Two-flop synchronizer bringing the jittery oscillator bit into the clk domain.
// Both flops are kept so that tools neither merge nor retime them.
module trng_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    (* keep = "true", async_reg = "true" *) logic meta_r;
    (* keep = "true", async_reg = "true" *) logic sync_r;

    // Metastability filter: first flop may go metastable, second settles it
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/trng_sampler.sv
// TRNG sampler: samples one ring-oscillator bit, von Neumann debiases the raw
// stream, packs bytes for a valid/ready consumer, and shuts the oscillator
// down when the repetition-count health test sees a stuck source.
// Note: rst_n is active-high (asserted when 1) to match the surrounding codebase.
module trng_sampler
    import trng_pkg::*;
#(
    parameter int SAMPLE_BIT = 0,
    parameter int SAMPLE_DIV = 16,
    parameter int WARMUP     = 256,
    parameter int RCT_LIMIT  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] ro_out,
    output logic        ro_rst,
    output logic        ro_activate,
    output logic [7:0]  rnd_byte,
    output logic        rnd_valid,
    input  logic        rnd_ready,
    output logic        health_fail
);

    localparam int DIV_W  = cnt_width(SAMPLE_DIV - 1);
    localparam int WARM_W = cnt_width(WARMUP - 1);
    localparam int RUN_W  = cnt_width(RCT_LIMIT);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);
    localparam logic [RUN_W-1:0]  RUN_LIMIT = RUN_W'(RCT_LIMIT);

    trng_state_e            state_r;
    logic [DIV_W-1:0]       div_r;
    logic [WARM_W-1:0]      warm_r;
    logic [RUN_W-1:0]       run_cnt_r;
    logic                   last_raw_r;
    logic                   pair_full_r;
    logic                   pair_bit_r;
    logic [6:0]             shift_r;
    logic [BIT_CNT_W-1:0]   bit_cnt_r;

    logic                   raw_sync_s;
    logic                   unused_ro_s;
    logic                   sample_tick_s;
    logic [RUN_W-1:0]       run_next_s;
    logic                   trip_s;
    logic                   deb_valid_s;
    logic                   byte_done_s;
    logic [7:0]             byte_s;
    logic                   handshake_s;
    logic                   load_s;

    // Only one bus bit carries the entropy; the rest of the counter is ignored
    assign unused_ro_s = ^ro_out;

    trng_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ro_out[SAMPLE_BIT]),
        .q     (raw_sync_s)
    );

    // Per-sample decisions: sample strobe, health run length, debias result, output load
    always_comb begin
        sample_tick_s = 1'b0;
        run_next_s    = run_cnt_r;
        trip_s        = 1'b0;
        deb_valid_s   = 1'b0;
        byte_done_s   = 1'b0;
        byte_s        = {shift_r, pair_bit_r};
        handshake_s   = rnd_valid & rnd_ready;
        load_s        = 1'b0;

        if ((state_r == ST_RUN) && (div_r == DIV_LAST)) begin
            sample_tick_s = 1'b1;
        end else begin
            sample_tick_s = 1'b0;
        end

        // A zero count means this is the first raw bit since the run began
        if ((run_cnt_r == RUN_W'(0)) || (raw_sync_s != last_raw_r)) begin
            run_next_s = RUN_W'(1);
        end else if (run_cnt_r == RUN_LIMIT) begin
            run_next_s = run_cnt_r;
        end else begin
            run_next_s = run_cnt_r + RUN_W'(1);
        end

        trip_s      = sample_tick_s & (run_next_s >= RUN_LIMIT);
        // 10 -> 1 and 01 -> 0: the kept bit is simply the first of the pair
        deb_valid_s = sample_tick_s & pair_full_r & (pair_bit_r != raw_sync_s);
        byte_done_s = deb_valid_s & (bit_cnt_r == BIT_CNT_W'(BYTE_BITS - 1));
        // A finished byte is dropped rather than stalling the sampler when the slot is busy
        load_s      = byte_done_s & ~trip_s & (~rnd_valid | handshake_s);
    end

    // Control FSM with registered oscillator control, sampling datapath and output slot
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_r     <= ST_IDLE;
            ro_rst      <= 1'b1;
            ro_activate <= 1'b0;
            rnd_byte    <= 8'd0;
            rnd_valid   <= 1'b0;
            health_fail <= 1'b0;
            div_r       <= DIV_W'(0);
            warm_r      <= WARM_W'(0);
            run_cnt_r   <= RUN_W'(0);
            last_raw_r  <= 1'b0;
            pair_full_r <= 1'b0;
            pair_bit_r  <= 1'b0;
            shift_r     <= 7'd0;
            bit_cnt_r   <= BIT_CNT_W'(0);
        end else if (!enable) begin
            // Dropping enable stops the source and clears everything in flight
            state_r     <= ST_IDLE;
            ro_rst      <= 1'b1;
            ro_activate <= 1'b0;
            rnd_valid   <= 1'b0;
            health_fail <= 1'b0;
            div_r       <= DIV_W'(0);
            warm_r      <= WARM_W'(0);
            run_cnt_r   <= RUN_W'(0);
            pair_full_r <= 1'b0;
            shift_r     <= 7'd0;
            bit_cnt_r   <= BIT_CNT_W'(0);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r     <= ST_WARMUP;
                    ro_rst      <= 1'b0;
                    ro_activate <= 1'b1;
                    warm_r      <= WARM_W'(0);
                    run_cnt_r   <= RUN_W'(0);
                end

                ST_WARMUP: begin
                    if (warm_r == WARM_LAST) begin
                        state_r <= ST_RUN;
                        div_r   <= DIV_W'(0);
                    end else begin
                        warm_r  <= warm_r + WARM_W'(1);
                    end
                end

                ST_RUN: begin
                    if (sample_tick_s) begin
                        div_r <= DIV_W'(0);
                    end else begin
                        div_r <= div_r + DIV_W'(1);
                    end

                    if (trip_s) begin
                        // Stuck source: shut the oscillator down and discard pending data
                        state_r     <= ST_FAIL;
                        ro_rst      <= 1'b1;
                        ro_activate <= 1'b0;
                        health_fail <= 1'b1;
                        rnd_valid   <= 1'b0;
                        pair_full_r <= 1'b0;
                        shift_r     <= 7'd0;
                        bit_cnt_r   <= BIT_CNT_W'(0);
                    end else begin
                        if (sample_tick_s) begin
                            run_cnt_r  <= run_next_s;
                            last_raw_r <= raw_sync_s;
                            if (!pair_full_r) begin
                                pair_full_r <= 1'b1;
                                pair_bit_r  <= raw_sync_s;
                            end else begin
                                pair_full_r <= 1'b0;
                                if (deb_valid_s) begin
                                    shift_r   <= byte_s[6:0];
                                    bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
                                end else begin
                                    shift_r   <= shift_r;
                                end
                            end
                        end else begin
                            run_cnt_r <= run_cnt_r;
                        end

                        if (load_s) begin
                            rnd_byte  <= byte_s;
                            rnd_valid <= 1'b1;
                        end else if (handshake_s) begin
                            rnd_valid <= 1'b0;
                        end else begin
                            rnd_valid <= rnd_valid;
                        end
                    end
                end

                ST_FAIL: begin
                    state_r     <= ST_FAIL;
                    ro_rst      <= 1'b1;
                    ro_activate <= 1'b0;
                    rnd_valid   <= 1'b0;
                end

                default: begin
                    state_r     <= ST_IDLE;
                    ro_rst      <= 1'b1;
                    ro_activate <= 1'b0;
                    rnd_valid   <= 1'b0;
                end
            endcase
        end
    end

endmodule
